// File: rtl/risk_pkg.sv
// Shared types and constants for the RISK strided tile sequencer.
// Holds the address geometry, the function codes, the FSM states and the descriptor struct.
package risk_pkg;

    localparam int ADDR_W     = 17;
    localparam int STRIDE_W   = 15;
    localparam int TILE       = 4;
    localparam int CNT_W      = 8;
    localparam int TILE_SHIFT = $clog2(TILE);

    localparam logic [2:0] RISK_FUNC_LOAD  = 3'b000;
    localparam logic [2:0] RISK_FUNC_STORE = 3'b001;
    localparam logic [2:0] RISK_FUNC_CLEAR = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FIN   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [2:0]          func;
        logic [4:0]          rnum;
        logic [ADDR_W-1:0]   base;
        logic [STRIDE_W-1:0] stride_x;
        logic [STRIDE_W-1:0] stride_y;
        logic [CNT_W-1:0]    tiles_x;
        logic [CNT_W-1:0]    tiles_y;
    } risk_desc_t;

    // Per-tile address step: the stride is zero-extended, then scaled by the tile edge.
    // The result is truncated to ADDR_W so accumulated addresses wrap.
    function automatic logic [ADDR_W-1:0] tile_step(input logic [STRIDE_W-1:0] stride);
        logic [ADDR_W-1:0] ext;
        ext = ADDR_W'(stride);
        return ext << TILE_SHIFT;
    endfunction

endpackage

// File: rtl/risk_tile_seq_if.sv
// Handshake bundles of the tile sequencer: the descriptor link from decode and the command link
// to the RISK unit. On each bundle, master is the side that drives valid.
interface risk_desc_if;
    import risk_pkg::*;

    logic                desc_valid;
    logic                desc_ready;
    logic [2:0]          desc_func;
    logic [4:0]          desc_reg;
    logic [ADDR_W-1:0]   desc_base;
    logic [STRIDE_W-1:0] desc_stride_x;
    logic [STRIDE_W-1:0] desc_stride_y;
    logic [CNT_W-1:0]    desc_tiles_x;
    logic [CNT_W-1:0]    desc_tiles_y;

    modport master (
        output desc_valid, desc_func, desc_reg, desc_base,
               desc_stride_x, desc_stride_y, desc_tiles_x, desc_tiles_y,
        input  desc_ready
    );

    modport slave (
        input  desc_valid, desc_func, desc_reg, desc_base,
               desc_stride_x, desc_stride_y, desc_tiles_x, desc_tiles_y,
        output desc_ready
    );
endinterface

interface risk_cmd_if;
    import risk_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_func;
    logic [4:0]          cmd_reg;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [STRIDE_W-1:0] cmd_stride_x;
    logic [STRIDE_W-1:0] cmd_stride_y;
    logic                cmd_last;

    modport master (
        output cmd_valid, cmd_func, cmd_reg, cmd_addr,
               cmd_stride_x, cmd_stride_y, cmd_last,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_reg, cmd_addr,
               cmd_stride_x, cmd_stride_y, cmd_last,
        output cmd_ready
    );
endinterface

// File: rtl/risk_tile_addr_gen.sv
// Row-major tile walker: the tx/ty tile counters plus the row-start and current-tile address
// accumulators. start loads base; step advances by one tile and is ignored on the last tile.
module risk_tile_addr_gen
    import risk_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                step,
    input  logic [ADDR_W-1:0]   base,
    input  logic [STRIDE_W-1:0] stride_x,
    input  logic [STRIDE_W-1:0] stride_y,
    input  logic [CNT_W-1:0]    tiles_x,
    input  logic [CNT_W-1:0]    tiles_y,
    output logic [ADDR_W-1:0]   addr,
    output logic                last
);

    logic [CNT_W-1:0]  tx_reg, tx_next;
    logic [CNT_W-1:0]  ty_reg, ty_next;
    logic [ADDR_W-1:0] row_reg, row_next;
    logic [ADDR_W-1:0] cur_reg, cur_next;
    logic              row_end;

    assign row_end = (tx_reg == tiles_x - CNT_W'(1));
    assign last    = row_end && (ty_reg == tiles_y - CNT_W'(1));
    assign addr    = cur_reg;

    always_comb begin
        tx_next  = tx_reg;
        ty_next  = ty_reg;
        row_next = row_reg;
        cur_next = cur_reg;
        if (start) begin
            tx_next  = '0;
            ty_next  = '0;
            row_next = base;
            cur_next = base;
        end else if (step && !last) begin
            if (row_end) begin
                // Wrap to the first tile of the next tile row.
                tx_next  = '0;
                ty_next  = ty_reg + CNT_W'(1);
                row_next = row_reg + tile_step(stride_y);
                cur_next = row_next;
            end else begin
                tx_next  = tx_reg + CNT_W'(1);
                cur_next = cur_reg + tile_step(stride_x);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_reg  <= '0;
            ty_reg  <= '0;
            row_reg <= '0;
            cur_reg <= '0;
        end else begin
            tx_reg  <= tx_next;
            ty_reg  <= ty_next;
            row_reg <= row_next;
            cur_reg <= cur_next;
        end
    end

endmodule

// File: rtl/risk_tile_seq.sv
// RISK tile sequencer: takes one matrix-walk descriptor and issues one command per 4x4 tile.
// Define RISK_SEQ_PERF_EN to add the stall_cnt output (cycles with a command held back).
module risk_tile_seq
    import risk_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    risk_desc_if.slave  desc,
    risk_cmd_if.master  cmd,
    output logic        busy,
    output logic        done
`ifdef RISK_SEQ_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    seq_state_t        state_reg;
    risk_desc_t        desc_reg;
    risk_desc_t        desc_in;
    logic              desc_ready_reg;
    logic              cmd_valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              accept;
    logic              step;
    logic              gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [ADDR_W-1:0] gen_base;

    assign desc_in = '{
        func:     desc.desc_func,
        rnum:     desc.desc_reg,
        base:     desc.desc_base,
        stride_x: desc.desc_stride_x,
        stride_y: desc.desc_stride_y,
        tiles_x:  desc.desc_tiles_x,
        tiles_y:  desc.desc_tiles_y
    };

    assign accept   = (state_reg == IDLE) && desc.desc_valid;
    // In ISSUE cmd_valid is always high, so cmd_ready alone marks a handshake.
    assign step     = (state_reg == ISSUE) && cmd.cmd_ready;
    assign gen_base = accept ? desc_in.base : desc_reg.base;

    risk_tile_addr_gen u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .step     (step),
        .base     (gen_base),
        .stride_x (desc_reg.stride_x),
        .stride_y (desc_reg.stride_y),
        .tiles_x  (desc_reg.tiles_x),
        .tiles_y  (desc_reg.tiles_y),
        .addr     (gen_addr),
        .last     (gen_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            desc_reg       <= '0;
            desc_ready_reg <= 1'b1;
            cmd_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (desc.desc_valid) begin
                        desc_reg       <= desc_in;
                        desc_ready_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                        // An empty walk skips ISSUE and completes immediately.
                        if (desc_in.tiles_x == '0 || desc_in.tiles_y == '0) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= ISSUE;
                            cmd_valid_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd.cmd_ready && gen_last) begin
                        state_reg     <= FIN;
                        cmd_valid_reg <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                FIN: begin
                    state_reg      <= IDLE;
                    done_reg       <= 1'b0;
                    busy_reg       <= 1'b0;
                    desc_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg      <= IDLE;
                    cmd_valid_reg  <= 1'b0;
                    done_reg       <= 1'b0;
                    busy_reg       <= 1'b0;
                    desc_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign desc.desc_ready  = desc_ready_reg;
    assign cmd.cmd_valid    = cmd_valid_reg;
    assign cmd.cmd_func     = desc_reg.func;
    assign cmd.cmd_reg      = desc_reg.rnum;
    assign cmd.cmd_addr     = gen_addr;
    assign cmd.cmd_stride_x = desc_reg.stride_x;
    assign cmd.cmd_stride_y = desc_reg.stride_y;
    assign cmd.cmd_last     = cmd_valid_reg && gen_last;
    assign busy             = busy_reg;
    assign done             = done_reg;

`ifdef RISK_SEQ_PERF_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (accept) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == ISSUE && !cmd.cmd_ready && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
